// File: rtl/my_spi_master.sv
// my_spi_master
//   Register-access SPI master, mode 0 (clock idles low, data sampled on the
//   rising edge). Each transaction sends an address byte {wr, addr[6:0]} and
//   then a data byte, MSB first, while shifting in one byte from the slave
//   during the data phase.
//
// Ports
//   theClock  in   system clock, all logic on its rising edge
//   theReset  in   synchronous active-high reset
//   start     in   transaction request, only looked at while idle
//   wr        in   1 = register write, 0 = register read
//   addr      in   [6:0] register address
//   wdata     in   [7:0] write data
//   busy      out  transaction in progress (SETUP through OFF)
//   done      out  one-cycle pulse in the first OFF cycle
//   rdata     out  [7:0] byte received during the data phase
//   spi_clk   out  SPI clock, idles low
//   spi_cs    out  active-low chip select
//   spi_sdo   out  master-out serial data
//   spi_sdi   in   master-in serial data, asynchronous to theClock
module my_spi_master #(
  parameter int unsigned HALF_DIV  = 4,  // cycles per SPI clock half-period (4..255)
  parameter int unsigned SETUP_CYC = 4,  // CS-low cycles before the first SPI edge
  parameter int unsigned GAP_CYC   = 4,  // idle-low clock cycles between the two bytes
  parameter int unsigned HOLD_CYC  = 4,  // CS-low cycles after the last falling edge
  parameter int unsigned OFF_CYC   = 4   // minimum CS-high cycles between transactions
) (
  input  logic       theClock,
  input  logic       theReset,
  input  logic       start,
  input  logic       wr,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic       spi_clk,
  output logic       spi_cs,
  output logic       spi_sdo,
  input  logic       spi_sdi
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_ADDR  = 3'd2;
  localparam logic [2:0] S_GAP   = 3'd3;
  localparam logic [2:0] S_DATA  = 3'd4;
  localparam logic [2:0] S_HOLD  = 3'd5;
  localparam logic [2:0] S_OFF   = 3'd6;

  localparam logic [7:0] HALF_LAST  = 8'(HALF_DIV - 1);
  localparam logic [7:0] SETUP_LAST = 8'(SETUP_CYC - 1);
  localparam logic [7:0] GAP_LAST   = 8'(GAP_CYC - 1);
  localparam logic [7:0] HOLD_LAST  = 8'(HOLD_CYC - 1);
  localparam logic [7:0] OFF_LAST   = 8'(OFF_CYC - 1);

  logic [2:0] r_state;
  logic [7:0] r_cnt;
  logic [2:0] r_bit;
  logic [7:0] r_tx;
  logic [7:0] r_dbyte;
  logic [7:0] r_rx;
  logic [7:0] r_rdata;
  logic       r_sclk;
  logic       r_cs;
  logic       r_sdo;
  logic       r_busy;
  logic       r_done;
  logic       r_sdi_meta;
  logic       r_sdi_sync;
  logic       w_half_end;

  assign w_half_end = (r_cnt == HALF_LAST);

  always_ff @(posedge theClock) begin
    if (theReset) begin
      r_sdi_meta <= 1'b0;
      r_sdi_sync <= 1'b0;
    end else begin
      r_sdi_meta <= spi_sdi;
      r_sdi_sync <= r_sdi_meta;
    end
  end

  always_ff @(posedge theClock) begin
    if (theReset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_tx    <= '0;
      r_dbyte <= '0;
      r_rx    <= '0;
      r_rdata <= '0;
      r_sclk  <= 1'b0;
      r_cs    <= 1'b1;
      r_sdo   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_SETUP;
            r_tx    <= {wr, addr};
            r_dbyte <= wdata;
            r_sdo   <= wr;
            r_cs    <= 1'b0;
            r_busy  <= 1'b1;
            r_cnt   <= '0;
          end
        end
        S_SETUP: begin
          if (r_cnt == SETUP_LAST) begin
            r_state <= S_ADDR;
            r_cnt   <= '0;
            r_bit   <= '0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_ADDR, S_DATA: begin
          if (w_half_end) begin
            r_cnt <= '0;
            if (!r_sclk) begin
              r_sclk <= 1'b1;
              if (r_state == S_DATA) begin
                r_rx <= {r_rx[6:0], r_sdi_sync};
              end
            end else begin
              // sdo moves on the same edge that drops spi_clk, so it is only
              // ever seen changing with the clock low.
              r_sclk <= 1'b0;
              r_bit  <= r_bit + 3'd1;
              if (r_bit == 3'd7) begin
                if (r_state == S_ADDR) begin
                  r_state <= S_GAP;
                  r_tx    <= r_dbyte;
                  r_sdo   <= r_dbyte[7];
                end else begin
                  r_state <= S_HOLD;
                  r_sdo   <= 1'b0;
                end
              end else begin
                r_tx  <= {r_tx[6:0], 1'b0};
                r_sdo <= r_tx[6];
              end
            end
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_GAP: begin
          if (r_cnt == GAP_LAST) begin
            r_state <= S_DATA;
            r_cnt   <= '0;
            r_bit   <= '0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_HOLD: begin
          if (r_cnt == HOLD_LAST) begin
            r_state <= S_OFF;
            r_cnt   <= '0;
            r_cs    <= 1'b1;
            r_done  <= 1'b1;
            r_rdata <= r_rx;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_OFF: begin
          if (r_cnt == OFF_LAST) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cs    <= 1'b1;
          r_sclk  <= 1'b0;
          r_sdo   <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign rdata   = r_rdata;
  assign spi_clk = r_sclk;
  assign spi_cs  = r_cs;
  assign spi_sdo = r_sdo;

endmodule

// File: tb/tb_my_spi_master.sv
// tb_my_spi_master
//   Scoreboard bench for my_spi_master at default parameters. Stimulus pushes
//   the hand-computed expected sdo stream and rdata per transaction; a monitor
//   on the falling system clock plays the SPI slave and pops/compares on done.
module tb_my_spi_master;

  typedef struct packed {
    logic        wr;
    logic [6:0]  addr;
    logic [7:0]  wdata;
    logic [7:0]  slave;
    logic [15:0] exp_sdo;
    logic [7:0]  exp_rd;
  } vec_t;

  typedef struct packed {
    logic [15:0] sdo;
    logic [7:0]  rd;
  } exp_t;

  logic       theClock = 1'b0;
  logic       theReset = 1'b1;
  logic       start    = 1'b0;
  logic       wr       = 1'b0;
  logic [6:0] addr     = '0;
  logic [7:0] wdata    = '0;
  logic       spi_sdi  = 1'b0;
  logic       busy;
  logic       done;
  logic [7:0] rdata;
  logic       spi_clk;
  logic       spi_cs;
  logic       spi_sdo;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb_q[$];
  vec_t vecs[7];

  logic [7:0] slave_byte = '0;
  logic       mon_en     = 1'b0;
  logic       chk_req    = 1'b0;
  int         rcnt       = 0;

  always #5 theClock = ~theClock;

  my_spi_master #(
    .HALF_DIV (4),
    .SETUP_CYC(4),
    .GAP_CYC  (4),
    .HOLD_CYC (4),
    .OFF_CYC  (4)
  ) dut (
    .theClock(theClock),
    .theReset(theReset),
    .start   (start),
    .wr      (wr),
    .addr    (addr),
    .wdata   (wdata),
    .busy    (busy),
    .done    (done),
    .rdata   (rdata),
    .spi_clk (spi_clk),
    .spi_cs  (spi_cs),
    .spi_sdo (spi_sdo),
    .spi_sdi (spi_sdi)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor + slave model
  logic        prev_cs = 1'b1, prev_clk = 1'b0, prev_busy = 1'b0, prev_done = 1'b0;
  logic [15:0] cap = '0;
  logic [7:0]  sb;
  int          bcnt = 0, busy_lo = 0, cs_hi = 0;
  logic        seen_done = 1'b0, cs_checked = 1'b0, busy_checked = 1'b0;
  exp_t        e;

  always @(negedge theClock) begin
    if (mon_en) begin
      if (!chk_req) begin
        cs_checked   = 1'b0;
        busy_checked = 1'b0;
      end
      if (prev_cs && !spi_cs) begin
        if (chk_req && !cs_checked) begin
          check("b2b_cs_high_cycles", cs_hi, 5);
          cs_checked = 1'b1;
        end
        cap   = '0;
        rcnt  = 0;
        cs_hi = 0;
      end
      if (spi_cs) cs_hi++;
      if (!spi_cs && spi_clk && !prev_clk) begin
        cap = {cap[14:0], spi_sdo};
        rcnt++;
      end
      if (!spi_cs && !spi_clk && prev_clk && rcnt >= 8 && rcnt < 16) begin
        sb = slave_byte;
        spi_sdi = sb[15 - rcnt];
      end
      if (!prev_busy && busy) begin
        if (chk_req && !busy_checked) begin
          check("b2b_busy_low_cycles", busy_lo, 1);
          busy_checked = 1'b1;
        end
        bcnt = 0;
      end
      if (prev_busy && !busy) begin
        if (seen_done) check("busy_length", bcnt, 144);
        seen_done = 1'b0;
        bcnt      = 0;
        busy_lo   = 0;
      end
      if (busy) bcnt++;
      else busy_lo++;
      if (done) begin
        check("done_single_cycle", {31'd0, prev_done}, 0);
        if (sb_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_done: got done=1, expected no pending transaction (t=%0t)", $time);
        end else begin
          e = sb_q.pop_front();
          check("rdata", {24'd0, rdata}, {24'd0, e.rd});
          check("sdo_bits", {16'd0, cap}, {16'd0, e.sdo});
        end
        seen_done = 1'b1;
      end
      prev_cs   = spi_cs;
      prev_clk  = spi_clk;
      prev_busy = busy;
      prev_done = done;
    end
  end

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while (busy !== 1'b0 && k < 400) begin
      @(negedge theClock);
      k++;
    end
    if (busy !== 1'b0) check({name, "_idle_timeout"}, {31'd0, busy}, 0);
    repeat (3) @(negedge theClock);
  endtask

  task automatic run_txn(input int i, input bit pulse);
    @(negedge theClock);
    wr         = vecs[i].wr;
    addr       = vecs[i].addr;
    wdata      = vecs[i].wdata;
    slave_byte = vecs[i].slave;
    sb_q.push_back({vecs[i].exp_sdo, vecs[i].exp_rd});
    start = 1'b1;
    @(negedge theClock);
    start = 1'b0;
    if (pulse) begin
      repeat (40) @(negedge theClock);
      wr    = 1'b0;
      addr  = 7'h11;
      wdata = 8'h00;
      start = 1'b1;
      @(negedge theClock);
      start = 1'b0;
    end
    wait_idle("txn");
  endtask

  initial begin
    int k;
    //          wr    addr   wdata  slave  exp_sdo    exp_rd
    vecs[0] = '{1'b1, 7'h16, 8'hA5, 8'h5A, 16'h96A5, 8'h5A};
    vecs[1] = '{1'b0, 7'h02, 8'h00, 8'h3C, 16'h0200, 8'h3C};
    vecs[2] = '{1'b0, 7'h7F, 8'h00, 8'hFF, 16'h7F00, 8'hFF};
    vecs[3] = '{1'b0, 7'h55, 8'h00, 8'h00, 16'h5500, 8'h00};
    vecs[4] = '{1'b1, 7'h01, 8'h81, 8'hC3, 16'h8181, 8'hC3};
    vecs[5] = '{1'b0, 7'h40, 8'hFF, 8'h18, 16'h40FF, 8'h18};
    vecs[6] = '{1'b1, 7'h7E, 8'h3C, 8'h99, 16'hFE3C, 8'h99};

    // Reset state
    repeat (2) @(posedge theClock);
    @(negedge theClock);
    check("rst_cs", {31'd0, spi_cs}, 1);
    check("rst_clk", {31'd0, spi_clk}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_rdata", {24'd0, rdata}, 0);
    theReset = 1'b0;
    mon_en   = 1'b1;

    // Write (with an ignored start pulse mid-transaction), reads, constant sdi
    run_txn(0, 1'b1);
    run_txn(1, 1'b0);
    run_txn(2, 1'b0);
    run_txn(3, 1'b0);

    // Back-to-back with start held high
    @(negedge theClock);
    wr         = vecs[4].wr;
    addr       = vecs[4].addr;
    wdata      = vecs[4].wdata;
    slave_byte = vecs[4].slave;
    sb_q.push_back({vecs[4].exp_sdo, vecs[4].exp_rd});
    start = 1'b1;
    k = 0;
    while (done !== 1'b1 && k < 400) begin
      @(negedge theClock);
      k++;
    end
    check("b2b_first_done_seen", {31'd0, done}, 1);
    wr         = vecs[5].wr;
    addr       = vecs[5].addr;
    wdata      = vecs[5].wdata;
    slave_byte = vecs[5].slave;
    sb_q.push_back({vecs[5].exp_sdo, vecs[5].exp_rd});
    chk_req = 1'b1;
    k = 0;
    while (busy !== 1'b0 && k < 20) begin
      @(negedge theClock);
      k++;
    end
    k = 0;
    while (busy !== 1'b1 && k < 20) begin
      @(negedge theClock);
      k++;
    end
    check("b2b_second_started", {31'd0, busy}, 1);
    @(negedge theClock);
    start = 1'b0;
    wait_idle("b2b");
    chk_req = 1'b0;

    // Mid-transaction reset at the 3rd data bit, with start asserted alongside
    @(negedge theClock);
    wr         = 1'b0;
    addr       = 7'h33;
    wdata      = 8'h00;
    slave_byte = 8'hAA;
    start      = 1'b1;
    @(negedge theClock);
    start = 1'b0;
    k = 0;
    while (rcnt != 10 && k < 300) begin
      @(negedge theClock);
      k++;
    end
    check("abort_reached_data_bit3", rcnt, 10);
    theReset = 1'b1;
    start    = 1'b1;
    @(negedge theClock);
    theReset = 1'b0;
    start    = 1'b0;
    check("abort_cs", {31'd0, spi_cs}, 1);
    check("abort_clk", {31'd0, spi_clk}, 0);
    check("abort_sdo", {31'd0, spi_sdo}, 0);
    check("abort_busy_reset_priority", {31'd0, busy}, 0);
    check("abort_done", {31'd0, done}, 0);
    check("abort_rdata", {24'd0, rdata}, 0);
    repeat (160) @(negedge theClock);
    check("abort_stays_idle", {31'd0, busy}, 0);

    run_txn(6, 1'b0);

    repeat (5) @(negedge theClock);
    check("scoreboard_empty", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/my_spi_master.md
MY_SPI_MASTER -- requirements
Module: my_spi_master

Interface
REQ-001 SHALL have parameter HALF_DIV, default 4, system cycles per SPI clock half-period (legal values 4..255).
REQ-002 SHALL have parameter SETUP_CYC, default 4, CS-low cycles before the first SPI clock edge.
REQ-003 SHALL have parameter GAP_CYC, default 4, idle-low SPI clock cycles between the address byte and the data byte.
REQ-004 SHALL have parameter HOLD_CYC, default 4, CS-low cycles after the last falling SPI clock edge.
REQ-005 SHALL have parameter OFF_CYC, default 4, minimum CS-high cycles between transactions.
REQ-006 SHALL have port theClock, input, 1, the single system clock; all logic is on its rising edge.
REQ-007 SHALL have port theReset, input, 1, synchronous active-high reset.
REQ-008 SHALL have port start, input, 1, transaction request, sampled only in IDLE.
REQ-009 SHALL have port wr, input, 1, 1 = register write, 0 = register read.
REQ-010 SHALL have port addr, input, 7, register address.
REQ-011 SHALL have port wdata, input, 8, write data.
REQ-012 SHALL have port busy, output, 1, transaction in progress.
REQ-013 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-014 SHALL have port rdata, output, 8, data byte shifted in during the data phase.
REQ-015 SHALL have port spi_clk, output, 1, SPI clock; idles low.
REQ-016 SHALL have port spi_cs, output, 1, active-low chip select.
REQ-017 SHALL have port spi_sdo, output, 1, master-out serial data.
REQ-018 SHALL have port spi_sdi, input, 1, master-in serial data; asynchronous to theClock.

Function
REQ-019 SHALL implement the states IDLE, SETUP, ADDR, GAP, DATA, HOLD and OFF.
REQ-020 SHALL, in IDLE with start=1, latch {wr,addr} as the address byte and wdata as the data byte, and enter SETUP with busy=1 and spi_cs=0 from the next cycle.
REQ-021 SHALL ignore start in every state other than IDLE, with no queuing.
REQ-022 SHALL remain in SETUP for SETUP_CYC cycles with spi_clk=0 and spi_sdo equal to address-byte bit 7.
REQ-023 SHALL, in ADDR and DATA, send 8 bits MSB first, each as HALF_DIV cycles of spi_clk=0 followed by HALF_DIV cycles of spi_clk=1.
REQ-024 SHALL change spi_sdo only while spi_clk is low and hold it stable across each rising edge.
REQ-025 SHALL remain in GAP for GAP_CYC cycles with spi_clk=0 and spi_sdo equal to data-byte bit 7.
REQ-026 SHALL synchronize spi_sdi through 2 flip-flops.
REQ-027 SHALL shift the synchronized sdi value into the receive register on the theClock edge that drives spi_clk 0->1 during DATA only; sdi is ignored during ADDR.
REQ-028 SHALL remain in HOLD for HOLD_CYC cycles with spi_clk=0 and spi_cs=0, then enter OFF.
REQ-029 SHALL, in OFF, drive spi_cs=1 for OFF_CYC cycles, then return to IDLE and deassert busy.
REQ-030 SHALL pulse done for exactly the first OFF cycle and update rdata in that same cycle; rdata holds its value until the next done.
REQ-031 SHALL capture rdata for writes as well as reads.
REQ-032 SHALL keep busy high for exactly SETUP_CYC + 32*HALF_DIV + GAP_CYC + HOLD_CYC + OFF_CYC cycles, which is 144 cycles at the defaults.
REQ-033 SHALL accept a start held high continuously in the first IDLE cycle after busy falls, so CS is high for at least OFF_CYC+1 cycles between transactions.
REQ-034 SHALL size all cycle counters at 8 bits with no wrap-around within legal parameter values.
REQ-035 SHALL drive spi_sdo=0 in IDLE and OFF.

Reset
REQ-036 SHALL, on theReset=1 in any state including mid-transaction, produce on the next cycle: state IDLE, spi_cs=1, spi_clk=0, spi_sdo=0, busy=0, done=0, rdata=0x00, with no done pulse for the aborted transaction.
REQ-037 SHALL give theReset priority over start in the same cycle.

Verification
REQ-038 SHALL pass the reset test: theReset for 2 cycles -> spi_cs=1, spi_clk=0, busy=0, done=0, rdata=0x00.
REQ-039 SHALL pass the write test: wr=1, addr=0x16, wdata=0xA5 -> spi_sdo at the 16 rising edges is 1,0,0,1,0,1,1,0 then 1,0,1,0,0,1,0,1; busy high 144 cycles; one done pulse.
REQ-040 SHALL pass the read test: wr=0, addr=0x02 against a slave model returning 0x3C -> address byte 0x02 sent, rdata=0x3C when done=1.
REQ-041 SHALL pass the back-to-back test: start held high for 2 transactions -> second SETUP begins 1 cycle after busy falls, spi_cs high for at least 5 cycles between, and pulses on start while busy have no effect.
REQ-042 SHALL pass the mid-transaction reset test: theReset asserted at the 3rd data bit -> spi_cs=1 next cycle, no done pulse, and a following transaction completes normally.
REQ-043 SHALL pass the constant-sdi test: spi_sdi tied to 1 during a read -> rdata=0xFF; tied to 0 -> rdata=0x00.
